// File: rtl/pio_input_debounced_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | pio_input_debounced_if                                               |
// | Avalon-MM slave bus and interrupt line for the debounced input PIO.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface pio_input_debounced_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface
`default_nettype wire

// File: rtl/pio_input_debounced.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | pio_input_debounced                                                  |
// | Input PIO: synchroniser, per-bit debounce, edge capture and IRQ.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pio_input_debounced #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in_port,
  pio_input_debounced_if.slave bus
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] stable_prev_q, stable_prev_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] w1c;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rd_val;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wdata        = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;
  assign sync_d       = {sync_q[SYNC_STAGES-2:0], in_port};
  assign sync_out     = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      always_comb begin
        stable_d = sync_out;
      end
    end else begin : g_debounce
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

      // A bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int b = 0; b < WIDTH; b++) begin
          if (sync_out[b] != stable_q[b]) begin
            if (cnt_q[b] == CNT_LAST) begin
              stable_d[b] = ~stable_q[b];
              cnt_d[b]    = '0;
            end else begin
              cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
          end else begin
            cnt_d[b] = '0;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  always_comb begin
    stable_prev_d = stable_q;
    rise          = stable_q & ~stable_prev_q & rise_en_q;
    fall          = ~stable_q & stable_prev_q & fall_en_q;
    w1c           = (wr_en && bus.address == 3'd3) ? wdata : '0;
    // Set has priority over a simultaneous W1C so no edge is lost.
    cap_d         = (cap_q & ~w1c) | rise | fall;

    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    level_d    = level_q;
    if (wr_en) begin
      case (bus.address)
        3'd2:    irq_mask_d = wdata;
        3'd4:    rise_en_d  = wdata;
        3'd5:    fall_en_d  = wdata;
        3'd6:    level_d    = wdata;
        default: ;
      endcase
    end

    case (bus.address)
      3'd0:    rd_val = stable_q;
      3'd1:    rd_val = sync_out;
      3'd2:    rd_val = irq_mask_q;
      3'd3:    rd_val = cap_q;
      3'd4:    rd_val = rise_en_q;
      3'd5:    rd_val = fall_en_q;
      3'd6:    rd_val = level_q;
      default: rd_val = '0;
    endcase
    readdata_d              = '0;
    readdata_d[WIDTH-1:0]   = rd_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      irq_mask_q    <= '0;
      cap_q         <= '0;
      rise_en_q     <= '1;
      fall_en_q     <= '0;
      level_q       <= '0;
      readdata_q    <= '0;
    end else begin
      sync_q        <= sync_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      irq_mask_q    <= irq_mask_d;
      cap_q         <= cap_d;
      rise_en_q     <= rise_en_d;
      fall_en_q     <= fall_en_d;
      level_q       <= level_d;
      readdata_q    <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = |(irq_mask_q & ((level_q & stable_q) | (~level_q & cap_q)));

endmodule
`default_nettype wire

// File: tb/tb_pio_input_debounced.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pio_input_debounced                                               |
// | Scoreboarded bench: default instance and a 32-bit bypass instance.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_pio_input_debounced;
  localparam int W_A = 8;
  localparam int S_A = 2;
  localparam int D_A = 4;
  localparam int W_B = 32;
  localparam int S_B = 2;
  localparam int D_B = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_a, rst_b;
  logic [W_A-1:0] pin_a;
  logic [W_B-1:0] pin_b;
  logic           irq_chk;

  pio_input_debounced_if bus_a ();
  pio_input_debounced_if bus_b ();

  pio_input_debounced #(.WIDTH(W_A), .SYNC_STAGES(S_A), .DEBOUNCE_CYCLES(D_A)) dut_a (
    .clk(clk), .reset_n(rst_a), .in_port(pin_a), .bus(bus_a));
  pio_input_debounced #(.WIDTH(W_B), .SYNC_STAGES(S_B), .DEBOUNCE_CYCLES(D_B)) dut_b (
    .clk(clk), .reset_n(rst_b), .in_port(pin_b), .bus(bus_b));

  int checks = 0;
  int passes = 0;

  // Reference: pin history per clock edge; a stable bit flips once the last
  // D synchronised samples all disagree with it.
  typedef struct packed {
    logic [15:0][31:0] hist;
    logic [31:0] stable, stable_d, cap, mask, rise_en, fall_en, level;
  } model_t;

  typedef struct packed {
    logic [2:0]  addr;
    logic [31:0] exp;
  } rd_exp_t;

  model_t  m_a, m_b;
  rd_exp_t q_a[$];
  rd_exp_t q_b[$];

  function automatic logic [31:0] wmask(input int w);
    logic [31:0] one = 32'd1;
    return (w >= 32) ? 32'hFFFF_FFFF : ((one << w) - 32'd1);
  endfunction

  function automatic model_t m_reset(input int w);
    model_t n;
    n         = '0;
    n.rise_en = wmask(w);
    return n;
  endfunction

  function automatic model_t m_step(input model_t m, input logic [31:0] pin, input logic wr,
                                    input logic [2:0] addr, input logic [31:0] wd,
                                    input int w, input int s, input int d);
    model_t      n;
    logic [31:0] msk, nst, w1c, wdm;
    bit          all;
    n   = m;
    msk = wmask(w);
    wdm = wd & msk;
    for (int i = 15; i > 0; i--) n.hist[i] = m.hist[i-1];
    n.hist[0] = pin & msk;
    nst = m.stable;
    for (int b = 0; b < w; b++) begin
      if (d == 0) begin
        nst[b] = n.hist[s][b];
      end else begin
        all = 1'b1;
        for (int j = 0; j < d; j++) if (n.hist[s+j][b] == m.stable[b]) all = 1'b0;
        if (all) nst[b] = ~m.stable[b];
      end
    end
    w1c   = (wr && addr == 3'd3) ? wdm : 32'd0;
    n.cap = (m.cap & ~w1c) | (m.stable & ~m.stable_d & m.rise_en)
          | (~m.stable & m.stable_d & m.fall_en);
    if (wr) begin
      if (addr == 3'd2) n.mask    = wdm;
      if (addr == 3'd4) n.rise_en = wdm;
      if (addr == 3'd5) n.fall_en = wdm;
      if (addr == 3'd6) n.level   = wdm;
    end
    n.stable_d = m.stable;
    n.stable   = nst;
    return n;
  endfunction

  function automatic logic [31:0] m_read(input model_t m, input logic [2:0] addr, input int s);
    case (addr)
      3'd0:    return m.stable;
      3'd1:    return m.hist[s-1];
      3'd2:    return m.mask;
      3'd3:    return m.cap;
      3'd4:    return m.rise_en;
      3'd5:    return m.fall_en;
      3'd6:    return m.level;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq(input model_t m);
    return |(m.mask & ((m.level & m.stable) | (~m.level & m.cap)));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) m_a <= m_reset(W_A);
    else m_a <= m_step(m_a, 32'(pin_a), bus_a.chipselect & ~bus_a.write_n,
                       bus_a.address, bus_a.writedata, W_A, S_A, D_A);
  end

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) m_b <= m_reset(W_B);
    else m_b <= m_step(m_b, pin_b, bus_b.chipselect & ~bus_b.write_n,
                       bus_b.address, bus_b.writedata, W_B, S_B, D_B);
  end

  // Monitors: a read strobe at an edge means readdata is valid just after it.
  always @(posedge clk) begin
    if (rst_a && bus_a.chipselect && bus_a.write_n) begin
      rd_exp_t e;
      #1;
      if (q_a.size() == 0) begin
        check("rd_a_unexpected", 32'd1, 32'd0);
      end else begin
        e = q_a.pop_front();
        check($sformatf("rd_a addr%0d", e.addr), bus_a.readdata, e.exp);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_b && bus_b.chipselect && bus_b.write_n) begin
      rd_exp_t e;
      #1;
      if (q_b.size() == 0) begin
        check("rd_b_unexpected", 32'd1, 32'd0);
      end else begin
        e = q_b.pop_front();
        check($sformatf("rd_b addr%0d", e.addr), bus_b.readdata, e.exp);
      end
    end
  end

  always @(negedge clk) begin
    if (irq_chk && rst_a) check("irq_a", 32'(bus_a.irq), 32'(m_irq(m_a)));
    if (irq_chk && rst_b) check("irq_b", 32'(bus_b.irq), 32'(m_irq(m_b)));
  end

  task automatic bus_idle();
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
  endtask

  task automatic rd(input int which, input logic [2:0] addr);
    rd_exp_t e;
    e.addr = addr;
    if (which == 0) begin
      bus_a.address = addr; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b1;
      e.exp = m_read(m_a, addr, S_A);
      q_a.push_back(e);
    end else begin
      bus_b.address = addr; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1;
      e.exp = m_read(m_b, addr, S_B);
      q_b.push_back(e);
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    bus_a.address = addr; bus_a.writedata = data;
    bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    @(negedge clk);
    bus_idle();
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; irq_chk = 1'b0;
    pin_a = '0; pin_b = '0;
    bus_a.address = '0; bus_a.writedata = '0;
    bus_b.address = '0; bus_b.writedata = '0;
    bus_idle();
    repeat (3) @(negedge clk);
    rst_a = 1'b1; rst_b = 1'b1; irq_chk = 1'b1;

    for (int a = 0; a < 8; a++) rd(0, 3'(a));
    for (int a = 0; a < 8; a++) rd(1, 3'(a));

    // Short glitch is rejected, long pulse is captured.
    wr(3'd2, 32'h01);
    pin_a[0] = 1'b1;
    repeat (3) @(negedge clk);
    pin_a[0] = 1'b0;
    for (int i = 0; i < 12; i++) rd(0, (i % 2 == 0) ? 3'd0 : 3'd3);
    pin_a[0] = 1'b1;
    for (int i = 0; i < 10; i++) rd(0, (i % 2 == 0) ? 3'd0 : 3'd3);

    // W1C, including a clear colliding with a fresh capture on the same bit.
    pin_a[2] = 1'b1;
    repeat (8) @(negedge clk);
    rd(0, 3'd3);
    wr(3'd3, 32'h04);
    rd(0, 3'd3);
    pin_a[0] = 1'b0;
    repeat (8) @(negedge clk);
    pin_a[0] = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    wr(3'd3, 32'h01);
    rd(0, 3'd3);
    rd(0, 3'd3);

    // Falling-edge-only capture on bit 7.
    wr(3'd3, 32'hFF);
    wr(3'd4, 32'h00);
    wr(3'd5, 32'h80);
    pin_a[7] = 1'b1;
    repeat (10) @(negedge clk);
    rd(0, 3'd3);
    pin_a[7] = 1'b0;
    repeat (10) @(negedge clk);
    rd(0, 3'd3);

    // Level-mode interrupt on bit 1.
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h02);
    wr(3'd6, 32'h02);
    pin_a[1] = 1'b1;
    for (int i = 0; i < 10; i++) rd(0, 3'd0);
    pin_a[1] = 1'b0;
    for (int i = 0; i < 10; i++) rd(0, 3'd0);

    // 32-bit bypass instance, then asynchronous reset mid-toggle.
    pin_b = 32'hA5A5_A5A5;
    for (int i = 0; i < 5; i++) rd(1, 3'd0);
    pin_b = 32'h5A5A_5A5A;
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("rst_b readdata", bus_b.readdata, 32'd0);
    check("rst_b irq", 32'(bus_b.irq), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    for (int a = 0; a < 8; a++) rd(1, 3'(a));
    for (int i = 0; i < 5; i++) rd(1, 3'd0);

    // Randomised traffic on the default instance.
    wr(3'd3, 32'hFF);
    wr(3'd4, $urandom);
    wr(3'd5, $urandom);
    wr(3'd6, $urandom);
    wr(3'd2, $urandom);
    for (int i = 0; i < 400; i++) begin
      int op;
      pin_a = pin_a ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) pin_b = $urandom;
      op = $urandom_range(0, 9);
      if (op < 5)       rd(0, 3'($urandom_range(0, 7)));
      else if (op < 7)  wr(3'($urandom_range(0, 7)), $urandom);
      else if (op == 7) rd(1, 3'($urandom_range(0, 1)));
      else              @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("drain_a", 32'(q_a.size()), 32'd0);
    check("drain_b", 32'(q_b.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
